// File: rtl/setpoint_sequencer_if.sv
// Host/follower-facing signal bundle for setpoint_sequencer.
// The master modport is the host side (table loading, run control, feedback
// from the follower); the slave modport is the sequencer itself.
interface setpoint_sequencer_if #(
    parameter int bitwidth   = 8,
    parameter int depth      = 4,
    parameter int dwellwidth = 8
);
    localparam int index_w = $clog2(depth);

    logic                  load_enable;
    logic [index_w-1:0]    load_index;
    logic [bitwidth-1:0]   load_value;
    logic [dwellwidth-1:0] load_dwell;
    logic                  start;
    logic                  stop;
    logic [bitwidth-1:0]   feedback_value;
    logic [bitwidth-1:0]   target_value;
    logic [index_w-1:0]    index;
    logic                  busy;
    logic                  done;

    modport master (
        output load_enable, load_index, load_value, load_dwell,
        output start, stop, feedback_value,
        input  target_value, index, busy, done
    );

    modport slave (
        input  load_enable, load_index, load_value, load_dwell,
        input  start, stop, feedback_value,
        output target_value, index, busy, done
    );
endinterface

// File: rtl/setpoint_sequencer.sv
// setpoint_sequencer: steps a follower through a table of setpoints.
// Each entry is driven until the follower's output equals it exactly, held
// for the entry's dwell count, then the next entry is driven. The table may
// only be written while idle.
//
// Build option: define SETPOINT_SEQUENCER_LOOP_EN to make the run wrap from
// the last entry back to entry 0 (done pulses on every wrap, busy stays high
// until stop). Without it the run ends in IDLE after the last entry.
module setpoint_sequencer #(
    parameter int bitwidth   = 8,
    parameter int depth      = 4,
    parameter int dwellwidth = 8
) (
    input  logic clock,
    input  logic reset,
    setpoint_sequencer_if.slave bus
);
    localparam int index_w = $clog2(depth);
    localparam logic [index_w-1:0] last_index = index_w'(depth - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [bitwidth-1:0]   table_value [depth];
    logic [dwellwidth-1:0] table_dwell [depth];
    logic [bitwidth-1:0]   target_reg, target_next;
    logic [index_w-1:0]    index_reg, index_next;
    logic [index_w-1:0]    index_inc;
    logic [dwellwidth-1:0] count_reg, count_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  table_write;

    // Host writes are accepted only while no run is in progress.
    assign table_write = (state == IDLE) && bus.load_enable;
    assign index_inc   = index_reg + index_w'(1);

    // Setpoint/dwell table: cleared by reset, written from the host port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                table_value[i] <= '0;
                table_dwell[i] <= '0;
            end
        end else if (table_write) begin
            table_value[bus.load_index] <= bus.load_value;
            table_dwell[bus.load_index] <= bus.load_dwell;
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            target_reg <= '0;
            index_reg  <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            target_reg <= target_next;
            index_reg  <= index_next;
            count_reg  <= count_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // Next-state decode: start/track/dwell/advance, with stop taking priority.
    always_comb begin
        state_next  = state;
        target_next = target_reg;
        index_next  = index_reg;
        count_next  = count_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        unique case (state)
            IDLE: begin
                // The table read here sees the pre-write contents, so a
                // simultaneous write to entry 0 does not affect this start.
                if (bus.start && !bus.stop) begin
                    state_next  = TRACK;
                    index_next  = '0;
                    target_next = table_value[0];
                    busy_next   = 1'b1;
                end
            end

            TRACK: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (bus.feedback_value == target_reg) begin
                    state_next = DWELL;
                    count_next = table_dwell[index_reg];
                end
            end

            DWELL: begin
                // Feedback is deliberately ignored here: once arrived, the
                // entry is held for its full dwell.
                if (bus.stop) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (count_reg != '0) begin
                    count_next = count_reg - dwellwidth'(1);
                end else if (index_reg != last_index) begin
                    state_next  = TRACK;
                    index_next  = index_inc;
                    target_next = table_value[index_inc];
                end else begin
                    done_next = 1'b1;
`ifdef SETPOINT_SEQUENCER_LOOP_EN
                    state_next  = TRACK;
                    index_next  = '0;
                    target_next = table_value[0];
`else
                    // target_value and index hold the final entry.
                    state_next = IDLE;
                    busy_next  = 1'b0;
`endif
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.target_value = target_reg;
    assign bus.index        = index_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
endmodule

// File: tb/tb_setpoint_sequencer.sv
// Bench for setpoint_sequencer. A timeline model turns each run into a list
// of expected output changes (cycle, target, index, busy, done); a monitor
// compares every observed change of the output tuple against that list.
// The follower is a one-cycle register from target_value to feedback_value.
module tb_setpoint_sequencer;
    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
`ifdef SETPOINT_SEQUENCER_LOOP_EN
    localparam bit LOOP   = 1'b1;
    localparam int PASSES = 2;
`else
    localparam bit LOOP   = 1'b0;
    localparam int PASSES = 1;
`endif

    typedef struct {
        int cyc;
        int tgt;
        int idx;
        int busy;
        int done;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic stuck = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   errors = 0;

    ev_t  plan[$];
    ev_t  sb[$];
    int   m_at[$];
    int   adv_at[$];
    logic [7:0] tab_v [DEPTH];
    logic [7:0] tab_d [DEPTH];
    int   model_tgt = 0;
    int   run_n = 0;
    int   stop_at = 0;
    int   reset_at = 0;
    int   busy_load_at = 0;
    bit   load_with_start = 1'b0;
    bit   mon_en = 1'b0;
    int   last_obs = 0;

    setpoint_sequencer_if #(.bitwidth(BW), .depth(DEPTH), .dwellwidth(DW)) bus ();

    setpoint_sequencer #(.bitwidth(BW), .depth(DEPTH), .dwellwidth(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Follower: output tracks target_value one cycle late, or sticks at 0.
    always @(posedge clock) bus.feedback_value <= stuck ? '0 : bus.target_value;

    function automatic int pack(int t, int i, int b, int d);
        return t * 16 + i * 4 + b * 2 + d;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every change of the output tuple must be the next expected event.
    always @(negedge clock) begin
        int  obs;
        ev_t e;
        if (mon_en) begin
            obs = pack(int'(bus.target_value), int'(bus.index), int'(bus.busy), int'(bus.done));
            if (obs != last_obs) begin
                last_obs = obs;
                if (sb.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_change: got tuple %0d at cycle %0d, required no change", obs, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_value", obs, pack(e.tgt, e.idx, e.busy, e.done));
                    chk("event_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Timeline of a run started at edge n; a change at edge c is matched
    // at c+1 if the value equals the previous one, else at c+2 (follower lag).
    function automatic void build(int n, int first, bit stuck_run);
        int cur, pv, cv, m, adv;
        plan.delete();
        m_at.delete();
        adv_at.delete();
        plan.push_back('{n, first, 0, 1, 0});
        if (!stuck_run) begin
            cur = n;
            pv  = model_tgt;
            cv  = first;
            for (int p = 0; p < PASSES; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m   = cur + ((cv == pv) ? 1 : 2);
                    adv = m + int'(tab_d[i]) + 1;
                    m_at.push_back(m);
                    adv_at.push_back(adv);
                    pv = cv;
                    if (i < DEPTH - 1) begin
                        cv = int'(tab_v[i + 1]);
                        plan.push_back('{adv, cv, i + 1, 1, 0});
                    end else if (LOOP) begin
                        cv = int'(tab_v[0]);
                        plan.push_back('{adv, cv, 0, 1, 1});
                        plan.push_back('{adv + 1, cv, 0, 1, 0});
                    end else begin
                        plan.push_back('{adv, cv, DEPTH - 1, 0, 1});
                        plan.push_back('{adv + 1, cv, DEPTH - 1, 0, 0});
                    end
                    cur = adv;
                end
            end
        end
    endfunction

    // Apply a stop or reset sampled at edge s to the planned timeline.
    function automatic void cut(int s, bit is_rst);
        int  k;
        ev_t last;
        k = 0;
        for (int i = 0; i < plan.size(); i++)
            if (plan[i].cyc < s) k = i;
        last = plan[k];
        if (is_rst || last.busy != 0) begin
            while (plan.size() > k + 1) void'(plan.pop_back());
            if (is_rst) begin
                if (pack(last.tgt, last.idx, last.busy, last.done) != 0)
                    plan.push_back('{s, 0, 0, 0, 0});
                for (int i = 0; i < DEPTH; i++) begin
                    tab_v[i] = '0;
                    tab_d[i] = '0;
                end
            end else begin
                plan.push_back('{s, last.tgt, last.idx, 0, 0});
            end
        end
    endfunction

    function automatic void launch(int first, bit stuck_run);
        run_n = cyc + 1;
        build(run_n, first, stuck_run);
    endfunction

    task automatic load(int i, int v, int d);
        bus.load_enable = 1'b1;
        bus.load_index  = 2'(i);
        bus.load_value  = 8'(v);
        bus.load_dwell  = 8'(d);
        @(negedge clock);
        bus.load_enable = 1'b0;
        tab_v[i] = 8'(v);
        tab_d[i] = 8'(d);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic execute();
        int endc;
        if (plan[$].busy != 0) begin
            stop_at = plan[$].cyc + 1;
            cut(stop_at, 1'b0);
        end
        foreach (plan[i]) sb.push_back(plan[i]);
        model_tgt = plan[$].tgt;
        bus.start = 1'b1;
        if (load_with_start) begin
            bus.load_enable = 1'b1;
            bus.load_index  = '0;
            bus.load_value  = 8'd9;
            bus.load_dwell  = 8'd1;
        end
        @(negedge clock);
        bus.start       = 1'b0;
        bus.load_enable = 1'b0;
        endc = plan[$].cyc + 3;
        while (cyc < endc) begin
            bus.stop        = (stop_at != 0) && (cyc == stop_at - 1);
            reset           = !((reset_at != 0) && (cyc == reset_at - 1));
            bus.load_enable = ((busy_load_at != 0) && (cyc == busy_load_at - 1)) ||
                              ((reset_at != 0) && (cyc == reset_at - 1));
            bus.load_index  = '0;
            bus.load_value  = 8'd9;
            bus.load_dwell  = 8'd1;
            @(negedge clock);
        end
        bus.stop        = 1'b0;
        reset           = 1'b1;
        bus.load_enable = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);
        stop_at         = 0;
        reset_at        = 0;
        busy_load_at    = 0;
        load_with_start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int old0;
        bus.load_enable = 1'b0;
        bus.load_index  = '0;
        bus.load_value  = '0;
        bus.load_dwell  = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tab_v[i] = '0;
            tab_d[i] = '0;
        end
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        chk("reset_target", int'(bus.target_value), 0);
        chk("reset_index", int'(bus.index), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        last_obs = 0;
        mon_en   = 1'b1;

        // Reference table run
        load(0, 5, 2);
        load(1, 12, 0);
        load(2, 2, 1);
        load(3, 7, 3);
        idle(3);
        launch(int'(tab_v[0]), 1'b0);
        execute();
        chk("end_busy", int'(bus.busy), 0);
        chk("end_target", int'(bus.target_value), LOOP ? 5 : 7);

        // Follower stuck at 0: sequencer must sit in TRACK until stopped
        stuck = 1'b1;
        launch(int'(tab_v[0]), 1'b1);
        stop_at = run_n + 50;
        cut(stop_at, 1'b0);
        execute();
        chk("stuck_target", int'(bus.target_value), 5);
        chk("stuck_done", int'(bus.done), 0);
        stuck = 1'b0;
        idle(3);

        // Stop on the advance edge of entry 1
        launch(int'(tab_v[0]), 1'b0);
        stop_at = adv_at[1];
        cut(stop_at, 1'b0);
        execute();
        chk("stop_dwell_index", int'(bus.index), 1);
        chk("stop_dwell_busy", int'(bus.busy), 0);
        idle(3);

        // Load while busy is ignored; restart still drives 5
        launch(int'(tab_v[0]), 1'b0);
        busy_load_at = run_n + 3;
        execute();
        idle(3);
        launch(int'(tab_v[0]), 1'b0);
        execute();
        idle(3);

        // Start and stop together in IDLE: stop wins, nothing happens
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        idle(3);
        chk("start_stop_busy", int'(bus.busy), 0);

        // Start with simultaneous write to entry 0 uses the old value
        old0 = int'(tab_v[0]);
        tab_v[0] = 8'd9;
        tab_d[0] = 8'd1;
        launch(old0, 1'b0);
        load_with_start = 1'b1;
        execute();
        idle(3);
        launch(int'(tab_v[0]), 1'b0);
        execute();
        idle(3);

        // Randomized tables, optional random stop
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++)
                load(i, (r % 2 == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 4)));
            idle(2);
            launch(int'(tab_v[0]), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                stop_at = int'($urandom_range(run_n + 1, plan[$].cyc));
                cut(stop_at, 1'b0);
            end
            execute();
            idle(2);
        end

        // Reset in the middle of entry 0's dwell clears outputs and table
        load(0, 4, 3);
        idle(2);
        launch(int'(tab_v[0]), 1'b0);
        reset_at = m_at[0] + 2;
        cut(reset_at, 1'b1);
        execute();
        chk("post_reset_target", int'(bus.target_value), 0);
        chk("post_reset_busy", int'(bus.busy), 0);
        idle(3);
        launch(int'(tab_v[0]), 1'b0);
        execute();
        chk("cleared_table_target", int'(bus.target_value), 0);

        idle(3);
        chk("final_queue_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
